pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the payload width in bits; legal range 1..1024.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width in bits; legal range 4..32.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: stage can accept.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: upstream payload, carrying control and data fields packed.
REQ-008 The block SHALL have port out_valid, output, 1 bit: downstream payload valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream can accept.
REQ-010 The block SHALL have port out_data, output, DATA_W bits: oldest held payload.
REQ-011 The block SHALL have port stall, input, 1 bit: global freeze of the output side, e.g. a memory busywait.
REQ-012 The block SHALL have port flush, input, 1 bit: discard all held payloads, used for branch/jump redirect.
REQ-013 The block SHALL have port clr_stats, input, 1 bit: synchronous clear of stall_cycles.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of held payloads, 0..2.
REQ-015 The block SHALL have port stall_cycles, output, CNT_W bits: saturating count of blocked-output cycles.

Function
REQ-016 The block SHALL define push = in_valid && in_ready and pop = out_valid && out_ready && !stall, both evaluated at the rising edge.
REQ-017 The block SHALL hold payloads in two registers, main and skid, in FIFO order, with a state machine EMPTY / ONE / TWO whose state equals occupancy.
REQ-018 In EMPTY, push SHALL load main and move to ONE.
REQ-019 In ONE, push without pop SHALL load skid and move to TWO.
REQ-020 In ONE, pop without push SHALL move to EMPTY.
REQ-021 In ONE, push with pop SHALL load main with in_data and remain in ONE.
REQ-022 In TWO, pop SHALL copy skid to main and move to ONE; push cannot occur in TWO.
REQ-023 The block SHALL drive in_ready = (state != TWO), decoded from the state register only, with no combinational path from out_ready, stall or in_valid.
REQ-024 The block SHALL drive out_valid = (state != EMPTY) and out_data = main when out_valid = 1, else all zeros, so that a bubble is a zero/NOP payload.
REQ-025 Latency SHALL be one cycle: a payload pushed at edge k appears on out_data after edge k when the stage was EMPTY, or when it was ONE and popped at the same edge.
REQ-026 Sustained throughput SHALL be one payload per cycle while out_ready = 1 and stall = 0.
REQ-027 While stall = 1, pop SHALL be 0, state and data SHALL be held except for a push that fills a free entry, and no payload SHALL be lost or duplicated.
REQ-028 flush = 1 SHALL force the next state to EMPTY and zero main and skid, overriding push and pop in the same cycle; in_data offered during that cycle SHALL be discarded.
REQ-029 flush SHALL take priority over stall.
REQ-030 stall_cycles SHALL increment by 1 on each edge where out_valid = 1, pop = 0 and flush = 0.
REQ-031 stall_cycles SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-032 clr_stats = 1 SHALL zero stall_cycles at the next edge, taking priority over increment.
REQ-033 flush SHALL NOT clear stall_cycles.

Reset
REQ-034 While rst = 1, state SHALL be EMPTY and main, skid and stall_cycles SHALL be 0, with in_ready = 1, out_valid = 0, out_data = 0 and occupancy = 0.
REQ-035 rst asserted mid-operation SHALL discard all held payloads immediately, with no clock edge required.
REQ-036 Pushes SHALL be ignored while rst = 1.

Verification
REQ-037 Scenario: DATA_W = 64; push 0xA1, 0xA2, 0xA3 on consecutive cycles with out_ready = 1 and stall = 0 -> out_data shows 0xA1, 0xA2, 0xA3 on consecutive cycles, occupancy stays 1, stall_cycles = 0.
REQ-038 Scenario: out_ready = 0; push 0x11 then 0x22 -> occupancy 2, in_ready = 0; then raise out_ready -> outputs 0x11 then 0x22, and in_ready returns to 1 one edge after the first pop.
REQ-039 Scenario: stage in TWO; flush = 1 together with in_valid = 1 and out_ready = 1 -> next cycle occupancy 0, out_valid = 0, out_data = 0, and the pushed payload never appears.
REQ-040 Scenario: CNT_W = 4; hold one payload with stall = 1 for 20 cycles -> stall_cycles reads 15 and holds; pulse clr_stats -> reads 0 next cycle.
REQ-041 Scenario: occupancy 2; assert rst between clock edges -> out_valid = 0 and in_ready = 1 immediately; after release, push 0x5 -> out_data = 0x5 after one edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with FIFO ordering, flush, global stall and a
// saturating counter of cycles in which a valid output was held back.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // State encoding equals the number of held payloads.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic               push, pop;

    // in_ready comes from the state register alone, so no ready path ripples upstream.
    assign in_ready     = (state_q != TWO);
    assign out_valid    = (state_q != EMPTY);
    assign out_data     = out_valid ? main_q : '0;
    assign occupancy    = state_q;
    assign stall_cycles = stall_cycles_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready && !stall;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (pop) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (clr_stats) begin
            stall_cycles_d = '0;
        end else if (out_valid && !pop && !flush && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // NOTE: payload registers are reset too, so a bubble after reset is a clean all-zero NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= EMPTY;
            main_q         <= '0;
            skid_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q        <= state_d;
            main_q         <= main_d;
            skid_q         <= skid_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus queues expected payloads,
// a negedge monitor pops and compares whenever the DUT hands one over.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              stall;
    logic              flush;
    logic              clr_stats;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cycles;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] sb_q[$];

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stall        (stall),
        .flush        (flush),
        .clr_stats    (clr_stats),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, then advance to the next edge + 1.
    task automatic cyc(input logic v, input logic [63:0] d, input logic ordy,
                       input logic stl, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        if (fl) sb_q.delete();
        else if (v && in_ready && !rst) sb_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop happens at the coming edge, so compare the presented payload now.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !stall && !flush) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got 0x%0h expected no payload at %0t", out_data, $time);
            end else begin
                check("sb_data", out_data, sb_q.pop_front());
            end
        end else if (!out_valid) begin
            check("bubble_zero", out_data, 64'h0);
        end
    end

    logic [11:0] rdy_pat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0; clr_stats = 1'b0;
        #2;
        check("rst_in_ready",  in_ready,     1);
        check("rst_out_valid", out_valid,    0);
        check("rst_out_data",  out_data,     0);
        check("rst_occupancy", occupancy,    0);
        check("rst_stall_cyc", stall_cycles, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back stream, one cycle latency, occupancy stays 1.
        cyc(1, 64'hA1, 1, 0, 0); check("s1_occ_a1", occupancy, 1); check("s1_data_a1", out_data, 64'hA1);
        cyc(1, 64'hA2, 1, 0, 0); check("s1_occ_a2", occupancy, 1); check("s1_data_a2", out_data, 64'hA2);
        cyc(1, 64'hA3, 1, 0, 0); check("s1_occ_a3", occupancy, 1); check("s1_data_a3", out_data, 64'hA3);
        cyc(0, 64'h0, 1, 0, 0);  check("s1_occ_end", occupancy, 0);
        check("s1_stall_cyc", stall_cycles, 0);

        // Backpressure fills the skid, then drains in order.
        cyc(1, 64'h11, 0, 0, 0); check("s2_occ1", occupancy, 1);
        cyc(1, 64'h22, 0, 0, 0); check("s2_occ2", occupancy, 2); check("s2_in_ready0", in_ready, 0);
        check("s2_stall_cyc", stall_cycles, 1);
        cyc(0, 64'h0, 1, 0, 0);  check("s2_in_ready1", in_ready, 1); check("s2_occ_after_pop", occupancy, 1);
        check("s2_data_22", out_data, 64'h22);
        cyc(0, 64'h0, 1, 0, 0);  check("s2_occ_drained", occupancy, 0);
        clr_stats = 1'b1; cyc(0, 64'h0, 0, 0, 0); clr_stats = 1'b0;
        check("s2_clr", stall_cycles, 0);

        // Flush from TWO with a simultaneous push attempt.
        cyc(1, 64'h31, 0, 0, 0);
        cyc(1, 64'h32, 0, 0, 0);
        check("s3_occ2", occupancy, 2);
        cyc(1, 64'h33, 1, 0, 1);
        check("s3_occ0", occupancy, 0); check("s3_out_valid", out_valid, 0);
        check("s3_out_data", out_data, 0); check("s3_flush_keeps_cnt", stall_cycles, 1);
        // Flush from ONE where the push would otherwise be accepted; flush also beats stall.
        cyc(1, 64'h34, 0, 0, 0);
        cyc(1, 64'h35, 1, 1, 1);
        check("s3b_occ0", occupancy, 0); check("s3b_out_data", out_data, 0);
        cyc(0, 64'h0, 1, 0, 0);
        check("s3b_no_ghost", out_valid, 0);
        clr_stats = 1'b1; cyc(0, 64'h0, 0, 0, 0); clr_stats = 1'b0;

        // Long stall: counter saturates; a push during stall fills the free entry.
        cyc(1, 64'h44, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(i == 3, 64'h45, 1, 1, 0);
            if (i == 3)  check("s4_occ2_under_stall", occupancy, 2);
            if (i == 14) check("s4_cnt15", stall_cycles, 15);
        end
        check("s4_saturated", stall_cycles, 15);
        check("s4_data_held", out_data, 64'h44);
        clr_stats = 1'b1; cyc(0, 64'h0, 1, 1, 0); clr_stats = 1'b0;
        check("s4_clr_over_inc", stall_cycles, 0);
        cyc(0, 64'h0, 1, 0, 0);
        cyc(0, 64'h0, 1, 0, 0);
        check("s4_drained", occupancy, 0);

        // Mixed backpressure pattern with continuous offered payloads.
        rdy_pat = 12'b1011_0011_1010;
        for (int i = 0; i < 12; i++) cyc(1, 64'h100 + 64'(i), rdy_pat[i], 0, 0);
        for (int i = 0; i < 3; i++)  cyc(0, 64'h0, 1, 0, 0);
        check("s5_drained", occupancy, 0);
        clr_stats = 1'b1; cyc(0, 64'h0, 0, 0, 0); clr_stats = 1'b0;

        // Asynchronous reset between edges while holding two payloads.
        cyc(1, 64'h51, 0, 0, 0);
        cyc(1, 64'h52, 0, 0, 0);
        check("s6_occ2", occupancy, 2);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("s6_async_out_valid", out_valid, 0);
        check("s6_async_in_ready",  in_ready,  1);
        check("s6_async_occ",       occupancy, 0);
        check("s6_async_cnt",       stall_cycles, 0);
        @(posedge clk); #1;
        cyc(1, 64'h99, 1, 0, 0);
        check("s6_push_in_rst", occupancy, 0);
        rst = 1'b0;
        cyc(1, 64'h5, 0, 0, 0);
        check("s6_data_5", out_data, 64'h5);
        cyc(0, 64'h0, 1, 0, 0);
        check("s6_drained", occupancy, 0);

        @(negedge clk);
        check("sb_empty_at_end", 64'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
